// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with valid/ready handshakes on both sides.
// Logic/arith/shift ops finish in one clock; MUL, FMUL and DIV iterate one bit per clock.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_l,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_CMPR = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;
  localparam logic [3:0] OP_RSH  = 4'd9;
  localparam logic [3:0] OP_ARSH = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_FMUL = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam int             FM_TOP   = FRAC + WIDTH - 1;

  typedef enum logic [1:0] {IDLE, ITER, HOLD} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_isIter;

  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_magA;
  logic [WIDTH-1:0] r_magB;
  logic [WIDTH-1:0] r_origA;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_negRes;
  logic             r_negA;
  logic             r_bZero;
  logic             r_divOvf;

  logic [WIDTH-1:0] r_resLo;
  logic [WIDTH-1:0] r_resHi;
  logic             r_z, r_n, r_l, r_c, r_v, r_dz;

  assign in_ready  = rst_n & ((r_state == IDLE) | ((r_state == HOLD) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_isIter  = (opcode == OP_MUL) | (opcode == OP_FMUL) | (opcode == OP_DIV);
  assign out_valid = (r_state == HOLD);

  assign res_lo  = r_resLo;
  assign res_hi  = r_resHi;
  assign flag_z  = r_z;
  assign flag_n  = r_n;
  assign flag_l  = r_l;
  assign flag_c  = r_c;
  assign flag_v  = r_v;
  assign flag_dz = r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = w_isIter ? ITER : HOLD;
      ITER: if (r_cnt == CNT_LAST) w_nextState = HOLD;
      HOLD: begin
        if (w_accept)       w_nextState = w_isIter ? ITER : HOLD;
        else if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Single-cycle datapath, evaluated on the live operands at accept.
  logic [WIDTH:0]   w_sum, w_diff, w_lsh, w_rsh, w_arsh;
  logic [WIDTH-1:0] w_sLo;
  logic             w_sZ, w_sN, w_sL, w_sC, w_sV;
  logic             w_zFromLo, w_nFromLo;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_lsh  = {1'b0, b} << a;
  assign w_rsh  = {b, 1'b0} >> a;
  assign w_arsh = $signed({b, 1'b0}) >>> a;

  always_comb begin
    w_sLo = '0;
    w_sZ = 1'b0; w_sN = 1'b0; w_sL = 1'b0; w_sC = 1'b0; w_sV = 1'b0;
    w_zFromLo = 1'b0;
    w_nFromLo = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_sLo = w_sum[WIDTH-1:0];
        w_sC  = w_sum[WIDTH];
        w_sV  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        w_sL  = a < b;
        w_zFromLo = 1'b1; w_nFromLo = 1'b1;
      end
      OP_SUB: begin
        w_sLo = w_diff[WIDTH-1:0];
        w_sC  = w_diff[WIDTH];
        w_sV  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        w_sL  = a < b;
        w_zFromLo = 1'b1; w_nFromLo = 1'b1;
      end
      OP_CMP: begin
        w_sZ = a == b;
        w_sL = a < b;
        w_sN = $signed(a) < $signed(b);
      end
      OP_CMPR: begin
        w_sZ = a == b;
        w_sL = b < a;
        w_sN = $signed(b) < $signed(a);
      end
      OP_AND: begin w_sLo = a & b; w_zFromLo = 1'b1; w_nFromLo = 1'b1; end
      OP_OR:  begin w_sLo = a | b; w_zFromLo = 1'b1; w_nFromLo = 1'b1; end
      OP_XOR: begin w_sLo = a ^ b; w_zFromLo = 1'b1; w_nFromLo = 1'b1; end
      OP_NOT: begin w_sLo = ~a;    w_zFromLo = 1'b1; w_nFromLo = 1'b1; end
      // The extra guard bit in each shift vector catches the last bit shifted out.
      OP_LSH:  begin w_sLo = w_lsh[WIDTH-1:0];  w_sC = w_lsh[WIDTH]; w_zFromLo = 1'b1; end
      OP_RSH:  begin w_sLo = w_rsh[WIDTH:1];    w_sC = w_rsh[0];     w_zFromLo = 1'b1; end
      OP_ARSH: begin w_sLo = w_arsh[WIDTH:1];   w_sC = w_arsh[0];    w_zFromLo = 1'b1; end
      default: ;
    endcase
    if (w_zFromLo) w_sZ = (w_sLo == '0);
    if (w_nFromLo) w_sN = w_sLo[WIDTH-1];
  end

  // Iterative core works on magnitudes; signs are applied on the final step.
  logic [WIDTH-1:0]   w_magA, w_magB;
  logic [WIDTH:0]     w_mulSum, w_divShift;
  logic [WIDTH-1:0]   w_divTrial, w_stepAcc, w_stepQ;
  logic [2*WIDTH-1:0] w_prod, w_prodS;
  logic [WIDTH-1:0]   w_quot, w_rem;
  logic [2*WIDTH-1-FM_TOP:0] w_fmTop;

  assign w_magA     = a[WIDTH-1] ? -a : a;
  assign w_magB     = b[WIDTH-1] ? -b : b;
  assign w_mulSum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_magA} : '0);
  assign w_divShift = {r_acc, r_q[WIDTH-1]};
  assign w_divTrial = w_divShift[WIDTH-1:0] - r_magB;

  always_comb begin
    w_stepAcc = w_mulSum[WIDTH:1];
    w_stepQ   = {w_mulSum[0], r_q[WIDTH-1:1]};
    if (r_op == OP_DIV) begin
      if (w_divShift >= {1'b0, r_magB}) begin
        w_stepAcc = w_divTrial;
        w_stepQ   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_stepAcc = w_divShift[WIDTH-1:0];
        w_stepQ   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign w_prod  = {w_stepAcc, w_stepQ};
  assign w_prodS = r_negRes ? -w_prod : w_prod;
  assign w_quot  = r_negRes ? -w_stepQ : w_stepQ;
  assign w_rem   = r_negA ? -w_stepAcc : w_stepAcc;
  assign w_fmTop = w_prodS[2*WIDTH-1:FM_TOP];

  logic [WIDTH-1:0] w_fLo, w_fHi;
  logic             w_fZ, w_fN, w_fV, w_fDz;

  always_comb begin
    w_fLo = '0; w_fHi = '0;
    w_fZ = 1'b0; w_fN = 1'b0; w_fV = 1'b0; w_fDz = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_fLo = w_prodS[WIDTH-1:0];
        w_fHi = w_prodS[2*WIDTH-1:WIDTH];
        w_fZ  = (w_prodS == '0);
        w_fN  = w_prodS[2*WIDTH-1];
      end
      OP_FMUL: begin
        w_fLo = w_prodS[FM_TOP:FRAC];
        w_fV  = !((&w_fmTop) || (~|w_fmTop));
      end
      OP_DIV: begin
        if (r_bZero) begin
          w_fLo = '1;
          w_fHi = r_origA;
          w_fDz = 1'b1;
        end else begin
          w_fLo = w_quot;
          w_fHi = w_rem;
          w_fV  = r_divOvf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0; r_cnt <= '0; r_magA <= '0; r_magB <= '0; r_origA <= '0;
      r_acc <= '0; r_q <= '0; r_negRes <= 1'b0; r_negA <= 1'b0;
      r_bZero <= 1'b0; r_divOvf <= 1'b0;
      r_resLo <= '0; r_resHi <= '0;
      r_z <= 1'b0; r_n <= 1'b0; r_l <= 1'b0; r_c <= 1'b0; r_v <= 1'b0; r_dz <= 1'b0;
    end else if (w_accept) begin
      if (w_isIter) begin
        r_op     <= opcode;
        r_cnt    <= '0;
        r_magA   <= w_magA;
        r_magB   <= w_magB;
        r_origA  <= a;
        r_acc    <= '0;
        r_q      <= (opcode == OP_DIV) ? w_magA : w_magB;
        r_negRes <= a[WIDTH-1] ^ b[WIDTH-1];
        r_negA   <= a[WIDTH-1];
        r_bZero  <= (b == '0);
        r_divOvf <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
      end else begin
        r_resLo <= w_sLo; r_resHi <= '0;
        r_z <= w_sZ; r_n <= w_sN; r_l <= w_sL; r_c <= w_sC; r_v <= w_sV; r_dz <= 1'b0;
      end
    end else if (r_state == ITER) begin
      r_acc <= w_stepAcc;
      r_q   <= w_stepQ;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_resLo <= w_fLo; r_resHi <= w_fHi;
        r_z <= w_fZ; r_n <= w_fN; r_l <= 1'b0; r_c <= 1'b0; r_v <= w_fV; r_dz <= w_fDz;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu (WIDTH=16) with a queue scoreboard
// that is drained by an independent output monitor.
module tb_seq_alu;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_CMP = 4'd2, OP_CMPR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7;
  localparam logic [3:0] OP_LSH = 4'd8, OP_RSH = 4'd9, OP_ARSH = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11, OP_FMUL = 4'd12, OP_DIV = 4'd13;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  opcode;
  logic [15:0] a, b, res_lo, res_hi;
  logic        flag_z, flag_n, flag_l, flag_c, flag_v, flag_dz;
  logic [5:0]  flags;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [5:0]  fl;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  seq_alu #(.WIDTH(16), .FRAC(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res_lo(res_lo), .res_hi(res_hi), .flag_z(flag_z), .flag_n(flag_n),
    .flag_l(flag_l), .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz)
  );

  // Flag bundle order used by every expected value: {z, n, l, c, v, dz}.
  assign flags = {flag_z, flag_n, flag_l, flag_c, flag_v, flag_dz};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [15:0] eLo, input logic [15:0] eHi,
                         input logic [5:0] eFl, input string name);
    exp_t e;
    e.lo = eLo; e.hi = eHi; e.fl = eFl; e.name = name;
    sbq.push_back(e);
  endtask

  // Presents an op from a falling edge, holds it until the DUT takes it on a rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] eLo, input logic [15:0] eHi,
                               input logic [5:0] eFl, input string name, input bit push);
    bit took;
    took = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = av; b = bv;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin took = 1'b1; break; end
      @(negedge clk);
    end
    if (!took) checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
    else if (push) pushExp(eLo, eHi, eFl, name);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counted in cycles from the accepting cycle; in_ready must stay low while busy.
  task automatic waitResult(input string name, input int expLat);
    int lat;
    lat = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (out_valid) begin lat = j + 1; break; end
      checkOutput({name, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    checkOutput({name, "_latency"}, lat, expLat);
  endtask

  task automatic runOp(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eLo, input logic [15:0] eHi,
                       input logic [5:0] eFl, input string name);
    applyStimulus(op, av, bv, eLo, eHi, eFl, name, 1'b1);
    waitResult(name, (op == OP_MUL || op == OP_FMUL || op == OP_DIV) ? 17 : 1);
  endtask

  // Monitor: compares against the scoreboard only when a result is actually handed over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_output: got res_lo=%h res_hi=%h, expected no output", res_lo, res_hi);
        end else begin
          e = sbq.pop_front();
          checkOutput({e.name, "_res_lo"}, {16'd0, res_lo}, {16'd0, e.lo});
          checkOutput({e.name, "_res_hi"}, {16'd0, res_hi}, {16'd0, e.hi});
          checkOutput({e.name, "_flags"},  {26'd0, flags},  {26'd0, e.fl});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0; out_ready = 1'b1;

    #12;
    checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_res_lo",    {16'd0, res_lo},    32'd0);
    checkOutput("reset_res_hi",    {16'd0, res_hi},    32'd0);
    checkOutput("reset_flags",     {26'd0, flags},     32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    runOp(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 6'b010010, "add_ovf");
    runOp(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 6'b100100, "add_carry");
    runOp(OP_SUB,  16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 6'b011100, "sub_borrow");
    runOp(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 6'b000010, "sub_ovf");
    runOp(OP_CMP,  16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 6'b001000, "cmp");
    runOp(OP_CMPR, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 6'b010000, "cmpr");
    runOp(OP_CMP,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 6'b100000, "cmp_eq");
    runOp(OP_OR,   16'h1200, 16'h0034, 16'h1234, 16'h0000, 6'b000000, "or");
    runOp(OP_ARSH, 16'h0014, 16'h8001, 16'hFFFF, 16'h0000, 6'b000100, "arsh_20");
    runOp(OP_LSH,  16'h0001, 16'h8001, 16'h0002, 16'h0000, 6'b000100, "lsh_1");
    runOp(OP_LSH,  16'h0000, 16'h8001, 16'h8001, 16'h0000, 6'b000000, "lsh_0");
    runOp(OP_RSH,  16'h0010, 16'h7001, 16'h0000, 16'h0000, 6'b100000, "rsh_16");
    runOp(OP_RSH,  16'h0004, 16'h00F8, 16'h000F, 16'h0000, 6'b000100, "rsh_4");
    runOp(4'd14,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 6'b000000, "reserved");

    runOp(OP_MUL,  16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 6'b010000, "mul_neg");
    runOp(OP_MUL,  16'h0000, 16'h1234, 16'h0000, 16'h0000, 6'b100000, "mul_zero");
    runOp(OP_FMUL, 16'h2000, 16'h6000, 16'h3000, 16'h0000, 6'b000000, "fmul_half");
    runOp(OP_FMUL, 16'h7FFF, 16'h7FFF, 16'hFFFC, 16'h0000, 6'b000010, "fmul_ovf");
    runOp(OP_FMUL, 16'hFFFF, 16'h2000, 16'hFFFF, 16'h0000, 6'b000000, "fmul_floor");
    runOp(OP_DIV,  16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 6'b000000, "div_neg");
    runOp(OP_DIV,  16'h0064, 16'h0007, 16'h000E, 16'h0002, 6'b000000, "div_pos");
    runOp(OP_DIV,  16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 6'b000000, "div_negdiv");
    runOp(OP_DIV,  16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 6'b000001, "div_zero");
    runOp(OP_DIV,  16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 6'b000010, "div_minint");

    // Stall the consumer after an XOR; a pending AND must wait for the release.
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(OP_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0000, 6'b010000, "bp_xor", 1'b1);
    waitResult("bp_xor", 1);
    @(posedge clk);
    #1 in_valid = 1'b1; opcode = OP_AND; a = 16'h00FF; b = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_res_lo",    {16'd0, res_lo},    32'h0000_CCCC);
      checkOutput("bp_flags",     {26'd0, flags},     32'h0000_0010);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    pushExp(16'h000F, 16'h0000, 6'b000000, "b2b_and");
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitResult("b2b_and", 1);

    runOp(OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 6'b010000, "not");

    // Asynchronous reset in the middle of a divide throws the op away.
    applyStimulus(OP_DIV, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 6'b000000, "div_killed", 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_res_lo",    {16'd0, res_lo},    32'd0);
    checkOutput("midrst_res_hi",    {16'd0, res_hi},    32'd0);
    checkOutput("midrst_flags",     {26'd0, flags},     32'd0);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("midrst_no_stale_valid", stale, 0);

    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
